// File: rtl/y86_pkg.sv
// Y86-64 instruction encoding constants, fetch state type and the
// length-decode helpers shared by the fetch aligner and PC-predict logic.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] RNONE    = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   // True when the instruction carries a register-specifier byte.
   function automatic logic need_regids(input logic [3:0] icode);
      logic r;
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
         I_OPQ, I_PUSHQ, I_POPQ:                 r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   // True when the instruction carries an 8-byte constant word.
   function automatic logic need_valC(input logic [3:0] icode);
      logic r;
      case (icode)
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
         I_JXX, I_CALL:                          r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   // Encoded length in bytes; invalid icodes count as one byte.
   function automatic logic [3:0] ilen(input logic [3:0] icode);
      logic [3:0] len;
      if (need_regids(icode) && need_valC(icode)) begin
         len = 4'd10;
      end else if (need_valC(icode)) begin
         len = 4'd9;
      end else if (need_regids(icode)) begin
         len = 4'd2;
      end else begin
         len = 4'd1;
      end
      return len;
   endfunction

endpackage

// File: rtl/fetch_align_buf_if.sv
// Memory-side and decode-side handshake bundle of the fetch aligner.
// master = the aligner, slave = the memory/decode environment.
interface fetch_align_buf_if #(
   parameter int FETCH_BYTES = 4
);
   logic                     redirect;
   logic [63:0]              redirect_pc;
   logic                     mem_req_valid;
   logic                     mem_req_ready;
   logic [63:0]              mem_req_addr;
   logic                     mem_rsp_valid;
   logic [8*FETCH_BYTES-1:0] mem_rsp_data;
   logic                     ins_valid;
   logic                     ins_ready;
   logic [3:0]               icode;
   logic [3:0]               ifun;
   logic [3:0]               rA;
   logic [3:0]               rB;
   logic [63:0]              valC;
   logic [63:0]              valP;
   logic                     ins_invalid;

   modport master (
      input  redirect, redirect_pc, mem_req_ready, mem_rsp_valid,
             mem_rsp_data, ins_ready,
      output mem_req_valid, mem_req_addr, ins_valid, icode, ifun,
             rA, rB, valC, valP, ins_invalid
   );

   modport slave (
      output redirect, redirect_pc, mem_req_ready, mem_rsp_valid,
             mem_rsp_data, ins_ready,
      input  mem_req_valid, mem_req_addr, ins_valid, icode, ifun,
             rA, rB, valC, valP, ins_invalid
   );
endinterface

// File: rtl/y86_ilen.sv
// Combinational icode decode: length, field presence and validity.
module y86_ilen
   import y86_pkg::*;
(
   input  logic [3:0] icode_i,
   output logic [3:0] len_o,
   output logic       need_regids_o,
   output logic       need_valc_o,
   output logic       invalid_o
);

   assign len_o         = ilen(icode_i);
   assign need_regids_o = need_regids(icode_i);
   assign need_valc_o   = need_valC(icode_i);
   assign invalid_o     = (icode_i > I_POPQ);

endmodule

// File: rtl/fetch_align_buf.sv
// Buffered Y86-64 fetch front end: streams memory beats into a circular
// byte buffer and hands whole, aligned instructions to decode.
module fetch_align_buf
   import y86_pkg::*;
#(
   parameter int          FETCH_BYTES = 4,
   parameter int          BUF_BYTES   = 16,
   parameter logic [63:0] RESET_PC    = 64'h0
) (
   input logic               clk,
   input logic               rst,
   fetch_align_buf_if.master bus
);

   localparam int             PW        = $clog2(BUF_BYTES);
   localparam int             CW        = PW + 1;
   localparam logic [CW-1:0]  FETCH_CNT = CW'(FETCH_BYTES);
   localparam logic [CW-1:0]  BUF_CNT   = CW'(BUF_BYTES);
   localparam logic [PW-1:0]  FETCH_PTR = PW'(FETCH_BYTES);

   fetch_state_e  state_q, state_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   fetch_pc_q, fetch_pc_d, ins_pc_q, ins_pc_d;
   logic          outstanding_q, outstanding_d, discard_q, discard_d;
   logic [7:0]    byte_buf_q [BUF_BYTES];

   logic [7:0]    hb_s [10];
   logic [3:0]    len_s;
   logic          need_regids_s, need_valc_s, invalid_s, stop_s;
   logic [CW-1:0] free_s, len_cnt_s, add_s, sub_s;
   logic          mem_req_valid_s, req_fire_s, rsp_accept_s, rsp_write_s;
   logic          ins_valid_s, ins_fire_s, out_en_s;
   logic [63:0]   valc_s;
   logic [3:0]    ra_s, rb_s;

   // Gather the ten bytes from the head onward, wrapping at the buffer end.
   always_comb begin
      for (int k = 0; k < 10; k++) begin
         hb_s[k] = byte_buf_q[head_q + PW'(k)];
      end
   end

   y86_ilen u_ilen (
      .icode_i       (hb_s[0][7:4]),
      .len_o         (len_s),
      .need_regids_o (need_regids_s),
      .need_valc_o   (need_valc_s),
      .invalid_o     (invalid_s)
   );

   // Free space uses the registered count only, so a same-cycle pop never
   // lets a request through early.
   assign free_s          = BUF_CNT - count_q;
   assign len_cnt_s       = CW'(len_s);
   assign stop_s          = invalid_s || (hb_s[0][7:4] == I_HALT);
   assign mem_req_valid_s = (state_q == ST_RUN) && !outstanding_q && (free_s >= FETCH_CNT);
   assign req_fire_s      = mem_req_valid_s && bus.mem_req_ready;
   // A response only counts when we are actually waiting for one.
   assign rsp_accept_s    = bus.mem_rsp_valid && outstanding_q;
   assign rsp_write_s     = rsp_accept_s && !discard_q && !bus.redirect;
   assign ins_valid_s     = (state_q == ST_RUN) && (count_q != '0) && (count_q >= len_cnt_s);
   assign ins_fire_s      = ins_valid_s && bus.ins_ready && !bus.redirect;
   assign add_s           = rsp_write_s ? FETCH_CNT : '0;
   assign sub_s           = ins_fire_s ? len_cnt_s : '0;
   assign out_en_s        = (state_q != ST_IDLE);

   // Field assembly for the head instruction; absent fields read as RNONE/0.
   always_comb begin
      ra_s   = RNONE;
      rb_s   = RNONE;
      valc_s = 64'h0;
      if (need_regids_s) begin
         ra_s = hb_s[1][7:4];
         rb_s = hb_s[1][3:0];
      end else begin
         ra_s = RNONE;
         rb_s = RNONE;
      end
      if (need_valc_s) begin
         for (int k = 0; k < 8; k++) begin
            valc_s[8*k +: 8] = need_regids_s ? hb_s[k+2] : hb_s[k+1];
         end
      end else begin
         valc_s = 64'h0;
      end
   end

   assign bus.mem_req_valid = mem_req_valid_s;
   assign bus.mem_req_addr  = out_en_s ? fetch_pc_q : 64'h0;
   assign bus.ins_valid     = ins_valid_s;
   assign bus.icode         = out_en_s ? hb_s[0][7:4] : 4'h0;
   assign bus.ifun          = out_en_s ? hb_s[0][3:0] : 4'h0;
   assign bus.rA            = out_en_s ? ra_s : 4'h0;
   assign bus.rB            = out_en_s ? rb_s : 4'h0;
   assign bus.valC          = out_en_s ? valc_s : 64'h0;
   assign bus.valP          = out_en_s ? (ins_pc_q + {60'h0, len_s}) : 64'h0;
   assign bus.ins_invalid   = out_en_s && invalid_s;

   // FSM next state: redirect always restarts fetch, halt/invalid stops it.
   always_comb begin
      state_d = state_q;
      if (bus.redirect) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_RUN;
            ST_RUN:    state_d = (ins_fire_s && stop_s) ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath next state: pointers, occupancy, PCs and request tracking.
   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      fetch_pc_d    = fetch_pc_q;
      ins_pc_d      = ins_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      if (bus.redirect) begin
         head_d        = tail_q;
         count_d       = '0;
         fetch_pc_d    = bus.redirect_pc;
         ins_pc_d      = bus.redirect_pc;
         // Anything still in flight after this edge belongs to the old path.
         outstanding_d = req_fire_s || (outstanding_q && !bus.mem_rsp_valid);
         discard_d     = req_fire_s || (outstanding_q && !bus.mem_rsp_valid);
      end else begin
         if (req_fire_s) begin
            outstanding_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + 64'(FETCH_BYTES);
         end else if (rsp_accept_s) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
         end else begin
            outstanding_d = outstanding_q;
         end
         if (rsp_write_s) begin
            tail_d = tail_q + FETCH_PTR;
         end else begin
            tail_d = tail_q;
         end
         if (ins_fire_s) begin
            head_d   = head_q + PW'(len_s);
            ins_pc_d = ins_pc_q + {60'h0, len_s};
         end else begin
            head_d   = head_q;
            ins_pc_d = ins_pc_q;
         end
         count_d = count_q + add_s - sub_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Control/datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         fetch_pc_q    <= RESET_PC;
         ins_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         fetch_pc_q    <= fetch_pc_d;
         ins_pc_q      <= ins_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // Byte storage: a beat lands at the tail; contents need no reset because
   // count gates every read.
   always_ff @(posedge clk) begin
      if (rsp_write_s) begin
         for (int i = 0; i < FETCH_BYTES; i++) begin
            byte_buf_q[tail_q + PW'(i)] <= bus.mem_rsp_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_fetch_align_buf.sv
// Directed bench for fetch_align_buf with a byte-array memory model.
module tb_fetch_align_buf;

   localparam int FB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_align_buf_if #(.FETCH_BYTES(FB)) bus ();

   fetch_align_buf #(
      .FETCH_BYTES (FB),
      .BUF_BYTES   (16),
      .RESET_PC    (64'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256];
   int          errors = 0;
   int          checks = 0;
   int          rsp_delay = 0;
   int          req_seen = 0;
   logic        have_pend = 1'b0;
   logic [63:0] pend_addr = 64'h0;
   int          wait_cnt = 0;

   // Memory responder: one beat per accepted request, rsp_delay cycles late.
   initial begin
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_pend         = 1'b0;
            bus.mem_rsp_valid = 1'b0;
         end else begin
            if (have_pend && wait_cnt == 0) begin
               bus.mem_rsp_valid = 1'b1;
               for (int i = 0; i < FB; i++) begin
                  logic [7:0] a;
                  a = pend_addr[7:0] + 8'(i);
                  bus.mem_rsp_data[8*i +: 8] = mem[a];
               end
               have_pend = 1'b0;
            end else begin
               bus.mem_rsp_valid = 1'b0;
               if (have_pend) wait_cnt--;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               have_pend = 1'b1;
               pend_addr = bus.mem_req_addr;
               wait_cnt  = rsp_delay;
               req_seen++;
            end
         end
      end
   end

   task automatic load_mem(input logic [7:0] fill);
      for (int i = 0; i < 256; i++) mem[i] = fill;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.ins_ready   = 1'b0;
      rsp_delay       = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      load_mem(8'h10);
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.ins_ready   = 1'b0;
      rsp_delay       = 0;
      repeat (2) @(negedge clk);
      checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid got=%b exp=0", bus.ins_valid); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", bus.mem_req_valid); end
      checks++; if (bus.rA !== 4'h0 || bus.rB !== 4'h0) begin errors++; $display("FAIL rst_regs got=%h%h exp=00", bus.rA, bus.rB); end
      checks++; if (bus.valP !== 64'h0) begin errors++; $display("FAIL rst_valP got=%h exp=0", bus.valP); end
      checks++; if (bus.valC !== 64'h0 || bus.icode !== 4'h0 || bus.ins_invalid !== 1'b0) begin errors++; $display("FAIL rst_fields got=%h/%h/%b exp=0", bus.valC, bus.icode, bus.ins_invalid); end
      rst = 1'b0;
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got=%b exp=0", bus.mem_req_valid); end
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%b exp=1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 64'h0) begin errors++; $display("FAIL first_req_addr got=%h exp=0", bus.mem_req_addr); end
      @(negedge clk);
      checks++; if (bus.ins_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rsp_cycle got=%b/%b exp=0/0", bus.ins_valid, bus.mem_req_valid); end
      @(negedge clk);
      checks++; if (bus.ins_valid !== 1'b1) begin errors++; $display("FAIL first_ins_valid got=%b exp=1", bus.ins_valid); end
      checks++; if (bus.icode !== 4'h1 || bus.valP !== 64'h1 || bus.rA !== 4'hF) begin errors++; $display("FAIL first_nop got=%h/%h/%h exp=1/1/f", bus.icode, bus.valP, bus.rA); end
   endtask

   task automatic test_irmovq();
      bit found;
      load_mem(8'h10);
      mem[0] = 8'h30; mem[1] = 8'hF8; mem[2] = 8'h08;
      for (int i = 3; i < 10; i++) mem[i] = 8'h00;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL irmovq_timeout got=0 exp=ins_valid"); end
      checks++; if (bus.icode !== 4'h3 || bus.ifun !== 4'h0) begin errors++; $display("FAIL irmovq_code got=%h%h exp=30", bus.icode, bus.ifun); end
      checks++; if (bus.rA !== 4'hF || bus.rB !== 4'h8) begin errors++; $display("FAIL irmovq_regs got=%h%h exp=f8", bus.rA, bus.rB); end
      checks++; if (bus.valC !== 64'h8) begin errors++; $display("FAIL irmovq_valC got=%h exp=8", bus.valC); end
      checks++; if (bus.valP !== 64'd10 || bus.ins_invalid !== 1'b0) begin errors++; $display("FAIL irmovq_valP got=%h/%b exp=a/0", bus.valP, bus.ins_invalid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ic [4];
      logic [63:0] vp [4];
      logic [3:0]  ra [4];
      logic [3:0]  rb [4];
      int n;
      load_mem(8'h10);
      mem[2] = 8'h60; mem[3] = 8'h23; mem[4] = 8'h00;
      do_reset();
      bus.ins_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin
            ic[n] = bus.icode; vp[n] = bus.valP; ra[n] = bus.rA; rb[n] = bus.rB;
            n++;
            if (n == 4) break;
         end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n); end
      else begin
         checks++; if (ic[0] !== 4'h1 || vp[0] !== 64'd1) begin errors++; $display("FAIL b2b_nop0 got=%h/%h exp=1/1", ic[0], vp[0]); end
         checks++; if (ic[1] !== 4'h1 || vp[1] !== 64'd2) begin errors++; $display("FAIL b2b_nop1 got=%h/%h exp=1/2", ic[1], vp[1]); end
         checks++; if (ic[2] !== 4'h6 || vp[2] !== 64'd4 || ra[2] !== 4'h2 || rb[2] !== 4'h3) begin errors++; $display("FAIL b2b_opq got=%h/%h/%h%h exp=6/4/23", ic[2], vp[2], ra[2], rb[2]); end
         checks++; if (ic[3] !== 4'h0 || vp[3] !== 64'd5) begin errors++; $display("FAIL b2b_halt got=%h/%h exp=0/5", ic[3], vp[3]); end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (bus.mem_req_valid !== 1'b0 || bus.ins_valid !== 1'b0) begin errors++; $display("FAIL halted_quiet got=%b/%b exp=0/0", bus.mem_req_valid, bus.ins_valid); end
      end
   endtask

   task automatic test_backpressure();
      int r0;
      load_mem(8'h10);
      mem[0] = 8'h60; mem[1] = 8'h23;
      do_reset();
      r0 = req_seen;
      repeat (20) @(negedge clk);
      checks++; if (req_seen - r0 != 4) begin errors++; $display("FAIL bp_requests got=%0d exp=4", req_seen - r0); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got=%b exp=0", bus.mem_req_valid); end
      checks++; if (bus.ins_valid !== 1'b1 || bus.icode !== 4'h6 || bus.valP !== 64'd2) begin errors++; $display("FAIL bp_head got=%b/%h/%h exp=1/6/2", bus.ins_valid, bus.icode, bus.valP); end
      repeat (5) @(negedge clk);
      checks++; if (bus.ins_valid !== 1'b1 || bus.rA !== 4'h2 || bus.rB !== 4'h3 || bus.valP !== 64'd2) begin errors++; $display("FAIL bp_stable got=%b/%h%h/%h exp=1/23/2", bus.ins_valid, bus.rA, bus.rB, bus.valP); end
      checks++; if (req_seen - r0 != 4) begin errors++; $display("FAIL bp_no_more_req got=%0d exp=4", req_seen - r0); end
   endtask

   task automatic test_wrap();
      bit found;
      int nops;
      logic [63:0] vc, vp;
      load_mem(8'h10);
      mem[14] = 8'h80;
      mem[15] = 8'h88; mem[16] = 8'h77; mem[17] = 8'h66; mem[18] = 8'h55;
      mem[19] = 8'h44; mem[20] = 8'h33; mem[21] = 8'h22; mem[22] = 8'h11;
      mem[23] = 8'h00;
      do_reset();
      bus.ins_ready = 1'b1;
      found = 1'b0; nops = 0; vc = 64'h0; vp = 64'h0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.ins_valid && bus.icode == 4'h8) begin
            found = 1'b1; vc = bus.valC; vp = bus.valP;
            break;
         end else if (bus.ins_valid && bus.icode == 4'h1) begin
            nops++;
         end
      end
      bus.ins_ready = 1'b0;
      checks++; if (!found) begin errors++; $display("FAIL wrap_timeout got=0 exp=call"); end
      checks++; if (nops != 14) begin errors++; $display("FAIL wrap_nops got=%0d exp=14", nops); end
      checks++; if (vc !== 64'h1122334455667788) begin errors++; $display("FAIL wrap_valC got=%h exp=1122334455667788", vc); end
      checks++; if (vp !== 64'd23) begin errors++; $display("FAIL wrap_valP got=%0d exp=23", vp); end
   endtask

   task automatic test_redirect();
      bit found;
      load_mem(8'h10);
      mem[8'h40] = 8'h60; mem[8'h41] = 8'h12; mem[8'h42] = 8'h00;
      do_reset();
      rsp_delay     = 3;
      bus.ins_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_req_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL redir_first_req got=0 exp=1"); end
      @(negedge clk);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 64'h40;
      @(negedge clk);
      bus.redirect = 1'b0;
      checks++; if (bus.ins_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_after got=%b/%b exp=0/0", bus.ins_valid, bus.mem_req_valid); end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (bus.ins_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_valid got=1 exp=0"); end
         if (bus.mem_req_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found || bus.mem_req_addr !== 64'h40) begin errors++; $display("FAIL redir_req_addr got=%h exp=40", bus.mem_req_addr); end
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL redir_timeout got=0 exp=ins_valid"); end
      checks++; if (bus.icode !== 4'h6 || bus.rA !== 4'h1 || bus.rB !== 4'h2) begin errors++; $display("FAIL redir_ins got=%h/%h%h exp=6/12", bus.icode, bus.rA, bus.rB); end
      checks++; if (bus.valP !== 64'h42) begin errors++; $display("FAIL redir_valP got=%h exp=42", bus.valP); end
      bus.ins_ready = 1'b0;
   endtask

   task automatic test_invalid();
      bit found;
      load_mem(8'h10);
      mem[0] = 8'hE0;
      mem[8'h40] = 8'h60; mem[8'h41] = 8'h12;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL inv_timeout got=0 exp=ins_valid"); end
      checks++; if (bus.ins_invalid !== 1'b1 || bus.icode !== 4'hE) begin errors++; $display("FAIL inv_flag got=%b/%h exp=1/e", bus.ins_invalid, bus.icode); end
      checks++; if (bus.valP !== 64'd1 || bus.rA !== 4'hF || bus.rB !== 4'hF || bus.valC !== 64'h0) begin errors++; $display("FAIL inv_fields got=%h/%h%h/%h exp=1/ff/0", bus.valP, bus.rA, bus.rB, bus.valC); end
      bus.ins_ready = 1'b1;
      @(negedge clk);
      bus.ins_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.ins_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL inv_halted got=%b/%b exp=0/0", bus.ins_valid, bus.mem_req_valid); end
         @(negedge clk);
      end
      bus.redirect    = 1'b1;
      bus.redirect_pc = 64'h40;
      @(negedge clk);
      bus.redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found || bus.icode !== 4'h6 || bus.valP !== 64'h42) begin errors++; $display("FAIL inv_restart got=%b/%h/%h exp=1/6/42", found, bus.icode, bus.valP); end
   endtask

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.ins_ready   = 1'b0;
      test_reset();
      test_irmovq();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_redirect();
      test_invalid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_align_buf.md
# fetch_align_buf

Parametrised Y86-64 fetch aligner. It streams raw instruction bytes from an instruction-memory port of configurable beat width into a circular byte buffer, and decodes the head instruction's length from its icode. Once a whole instruction (1, 2, 9 or 10 bytes) is buffered, it presents the aligned icode, ifun, rA, rB, valC and valP to decode through a valid/ready handshake. It sits between the instruction memory and the decode stage, replacing the single-shot combinational align path with a buffered, redirectable fetch front end.

## Interface
Parameters:
- FETCH_BYTES, 4, bytes per memory beat; legal values are 1, 2, 4, 8.
- BUF_BYTES, 16, buffer depth; must be a power of two and ≥ 9+FETCH_BYTES.
- RESET_PC, 64'h0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- redirect  in  1  flush the buffer and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch and instruction PC.
- mem_req_valid  out  1  read request.
- mem_req_ready  in  1  request accepted.
- mem_req_addr  out  64  byte address of the beat.
- mem_rsp_valid  in  1  response beat present.
- mem_rsp_data  in  8*FETCH_BYTES  byte 0 in [7:0]; bytes are little-endian order.
- ins_valid  out  1  complete instruction at the head.
- ins_ready  in  1  decode accepts it.
- icode, ifun  out  4 each  byte0[7:4], byte0[3:0].
- rA, rB  out  4 each  byte1[7:4], byte1[3:0]; 4'hF when there is no regids byte.
- valC  out  64  little-endian; taken from bytes 2..9 when regids is present, otherwise bytes 1..8; 0 when absent.
- valP  out  64  instruction PC plus length.
- ins_invalid  out  1  head icode > 4'hB.

## Operation
- Instruction lengths:
  - 1 byte: halt(0), nop(1), ret(9), and any invalid icode.
  - 2 bytes: cmov(2), OPq(6), pushq(A), popq(B).
  - 9 bytes: jXX(7), call(8).
  - 10 bytes: irmovq(3), rmmovq(4), mrmovq(5).
- States:
  - IDLE: the reset state. Moves to RUN on the first edge after rst is released.
  - RUN: normal fetch and delivery.
  - HALTED: entered when a halt or invalid instruction is accepted. Issues no requests and holds ins_valid low.
  - redirect from any state moves to RUN.
- Request rule: mem_req_valid = RUN && !outstanding && free ≥ FETCH_BYTES.
  - free = BUF_BYTES − count.
  - free is computed from registered count only; same-cycle pops are ignored.
  - At most one request is outstanding.
  - On mem_req_valid && mem_req_ready: outstanding is set and fetch_pc += FETCH_BYTES.
- Response handling: on mem_rsp_valid, the beat is written at the tail, count += FETCH_BYTES, and outstanding is cleared.
  - If the discard flag is set, the beat is dropped and discard is cleared.
- Delivery: ins_valid = RUN && count ≥ 1 && count ≥ len(head byte).
  - Outputs are combinational from the buffer and stay stable until accepted.
  - On ins_valid && ins_ready: head += len, count −= len, ins_pc += len.
- Write and pop in the same cycle: count_next = count + FETCH_BYTES − len.
- Head and tail wrap modulo BUF_BYTES. Multi-byte fields are assembled across the wrap point.
- redirect (takes priority over everything):
  - count = 0, head = tail.
  - fetch_pc = ins_pc = redirect_pc.
  - The accept and response write of that cycle are ignored.
  - If a request is outstanding, discard is set and the later response is dropped.
  - A new request is not issued until outstanding is clear.
- Reset values:
  - state = IDLE.
  - fetch_pc = ins_pc = RESET_PC.
  - count, head, tail, outstanding, discard = 0.
  - Every output is 0 during reset, with rA and rB held at 0 rather than F.

## Timing
- Cycle after reset release: IDLE. Next cycle: mem_req_valid = 1 with mem_req_addr = RESET_PC.
- A beat written at edge N raises ins_valid in cycle N+1 if the head instruction is then complete.
- Zero-wait memory: request accepted at edge N, response at N+1, ins_valid at N+2.
- redirect at edge N: ins_valid is 0 in cycle N+1; a request to redirect_pc is issued in cycle N+1 when no request is outstanding.
- rst asserted mid-operation: all state clears immediately and asynchronously, and any in-flight response after release is ignored (count stays 0 until a new request).

## Structure
- Package y86_pkg holds:
  - icode localparams (I_HALT … I_POPQ).
  - Functions need_regids(icode), need_valC(icode) and ilen(icode) returning 4 bits.
  - The RNONE = 4'hF constant.
- Sub-module y86_ilen: combinational decode of icode into length, need_regids, need_valC and invalid. It is shared with the future PC-predict logic.
- The top level contains the FSM, byte buffer, pointers and field assembly.

## Test plan
- Memory bytes 30 f8 08 00 00 00 00 00 00 00 at 0, zero-wait memory, ins_ready = 1 → icode 3, ifun 0, rA F, rB 8, valC 8, valP 10.
- Back-to-back 10 10 60 23 00 at 0 → delivers nop, nop (valP 1, 2), OPq rA 2 rB 3 (valP 4), then halt; then HALTED with mem_req_valid = 0.
- ins_ready held 0 → buffer fills to count 16 (defaults); mem_req_valid drops once free < 4; outputs stay unchanged.
- call 80 at pc 14 with BUF_BYTES 16 → the instruction straddles the wrap point; valC is assembled correctly and valP = 23.
- redirect to 64'h40 while a response is outstanding → the stale beat is dropped; the first delivered instruction has ins_pc 0x40.
- icode E at head → ins_invalid = 1, valP = pc+1; after acceptance the block enters HALTED.
